// File: rtl/spi_reg_ctrl.sv
// Register-file controller behind an SPI slave byte interface.
// The first byte of a frame is a command (bit7 = read, bits[2:0] = start address); later bytes burst-write or burst-read.
module spi_reg_ctrl #(
    parameter logic [7:0] IDLE_BYTE   = 8'h5A,
    parameter logic [2:0] STATUS_ADDR = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    input  logic [7:0]  status_in,
    output logic [55:0] regs_out,
    output logic        wr_stb,
    output logic [2:0]  wr_addr
);

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_armed;
    logic        r_consumed;
    logic        r_ack;
    logic        r_stb;
    logic [2:0]  r_addr;
    logic [2:0]  r_wr_addr;
    logic [7:0]  r_tx;
    logic [7:0]  r_regs [7];

    logic        w_accept;
    logic        w_wr_en;
    logic [2:0]  w_load_addr;
    logic [7:0]  w_read_val;

    // r_consumed makes a level-held rx_valid count as a single byte.
    assign w_accept = rx_valid && !r_ack && !r_consumed && !cs && (r_state != IDLE);
    assign w_wr_en  = w_accept && (r_state == WRITE) && (r_addr != STATUS_ADDR);

    assign rx_ack  = r_ack && !cs;
    assign wr_stb  = r_stb && !cs;
    assign wr_addr = r_wr_addr;
    assign tx_data = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (cs) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (r_armed) w_next = CMD;
                CMD:     if (w_accept) w_next = rx_data[7] ? READ : WRITE;
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_load_addr = (r_state == CMD) ? rx_data[2:0] : r_addr + 3'd1;
        w_read_val  = status_in;
        for (int i = 0; i < 7; i++) begin
            if (w_load_addr == 3'(i) && w_load_addr != STATUS_ADDR) begin
                w_read_val = r_regs[i];
            end
        end
    end

    // After reset the FSM waits for a fresh cs high->low edge before framing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed    <= 1'b0;
            r_consumed <= 1'b0;
            r_ack      <= 1'b0;
            r_stb      <= 1'b0;
            r_addr     <= 3'd0;
            r_wr_addr  <= 3'd0;
            r_tx       <= IDLE_BYTE;
        end else begin
            r_ack <= w_accept;
            r_stb <= w_wr_en;
            if (cs) begin
                r_armed <= 1'b1;
            end
            if (!rx_valid) begin
                r_consumed <= 1'b0;
            end else if (w_accept) begin
                r_consumed <= 1'b1;
            end
            if (w_wr_en) begin
                r_wr_addr <= r_addr;
            end
            if (cs) begin
                r_tx <= IDLE_BYTE;
            end else if (w_accept) begin
                r_addr <= w_load_addr;
                if (r_state == READ || (r_state == CMD && rx_data[7])) begin
                    r_tx <= w_read_val;
                end else begin
                    r_tx <= IDLE_BYTE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (w_wr_en && r_addr == 3'(i)) begin
                    r_regs[i] <= rx_data;
                end
            end
        end
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < 7; i++) begin
            regs_out[8*i +: 8] = r_regs[i];
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: expected tx_data / wr_addr values are queued per byte sent
// and popped when the DUT acknowledges or strobes.
module tb_spi_reg_ctrl;

    localparam logic [7:0] IDLE_BYTE = 8'h5A;

    logic        clk;
    logic        rst;
    logic        cs;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic [7:0]  status_in;
    logic [55:0] regs_out;
    logic        wr_stb;
    logic [2:0]  wr_addr;

    spi_reg_ctrl #(.IDLE_BYTE(8'h5A), .STATUS_ADDR(3'd7)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .tx_data   (tx_data),
        .status_in (status_in),
        .regs_out  (regs_out),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         ackCount = 0;
    int         ackBase;
    logic [7:0] txQ [$];
    logic [2:0] wrQ [$];
    logic [7:0] regModel [8];
    logic [2:0] modelAddr;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [55:0] packModel();
        logic [55:0] r;
        for (int i = 0; i < 7; i++) r[8*i +: 8] = regModel[i];
        return r;
    endfunction

    function automatic logic [7:0] readValue(input logic [2:0] a);
        return (a == 3'd7) ? status_in : regModel[a];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_ack) begin
                ackCount++;
                if (txQ.size() == 0) checkOutput("ack_unexpected", 64'(1), 64'(0));
                else checkOutput("tx_data", 64'(tx_data), 64'(txQ.pop_front()));
            end
            if (wr_stb) begin
                if (wrQ.size() == 0) checkOutput("wr_stb_unexpected", 64'(1), 64'(0));
                else checkOutput("wr_addr", 64'(wr_addr), 64'(wrQ.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d);
        bit got;
        @(negedge clk);
        rx_data  = d;
        rx_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rx_ack) got = 1'b1;
        end
        if (!got) checkOutput("ack_timeout", 64'(0), 64'(1));
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic startFrame();
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("tx_idle_in_frame", 64'(tx_data), 64'(IDLE_BYTE));
    endtask

    task automatic endFrame();
        @(negedge clk);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("tx_after_frame", 64'(tx_data), 64'(IDLE_BYTE));
    endtask

    task automatic sendCmd(input logic [7:0] c);
        modelAddr = c[2:0];
        txQ.push_back(c[7] ? readValue(c[2:0]) : IDLE_BYTE);
        applyStimulus(c);
    endtask

    task automatic sendWrite(input logic [7:0] d);
        if (modelAddr != 3'd7) begin
            regModel[modelAddr] = d;
            wrQ.push_back(modelAddr);
        end
        txQ.push_back(IDLE_BYTE);
        modelAddr = modelAddr + 3'd1;
        applyStimulus(d);
    endtask

    task automatic sendDummy(input logic [7:0] d);
        modelAddr = modelAddr + 3'd1;
        txQ.push_back(readValue(modelAddr));
        applyStimulus(d);
    endtask

    task automatic checkRegs(input string tag);
        checkOutput(tag, 64'(regs_out), 64'(packModel()));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        cs        = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        status_in = 8'hC3;
        modelAddr = 3'd0;
        for (int i = 0; i < 8; i++) regModel[i] = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("rst_regs", 64'(regs_out), 64'(0));
        checkOutput("rst_tx", 64'(tx_data), 64'(IDLE_BYTE));
        checkOutput("rst_ack", 64'(rx_ack), 64'(0));
        checkOutput("rst_stb", 64'(wr_stb), 64'(0));
        checkOutput("rst_wr_addr", 64'(wr_addr), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic write burst
        ackBase = ackCount;
        startFrame();
        sendCmd(8'h02);
        sendWrite(8'hAA);
        sendWrite(8'hBB);
        endFrame();
        checkOutput("wr_acks", 64'(ackCount - ackBase), 64'(3));
        checkOutput("wr_reg2", 64'(regs_out[23:16]), 64'(8'hAA));
        checkOutput("wr_reg3", 64'(regs_out[31:24]), 64'(8'hBB));
        checkRegs("wr_regs");

        // preset registers 0x11..0x77
        startFrame();
        sendCmd(8'h00);
        for (int i = 0; i < 7; i++) sendWrite(8'(17 * (i + 1)));
        endFrame();
        checkRegs("preset_regs");

        // read burst into the status register (bits[6:3] of command ignored)
        startFrame();
        sendCmd(8'h85);
        sendDummy(8'h00);
        sendDummy(8'hFF);
        endFrame();
        checkRegs("rd_regs_unchanged");

        // read wrap 7->0 with a different live status value
        status_in = 8'h3C;
        startFrame();
        sendCmd(8'hF7);
        sendDummy(8'h12);
        sendDummy(8'h34);
        endFrame();
        checkRegs("rdwrap_regs_unchanged");

        // write wrap: status address dropped, then reg0
        startFrame();
        sendCmd(8'h06);
        sendWrite(8'h01);
        sendWrite(8'h02);
        sendWrite(8'h03);
        endFrame();
        checkOutput("wrap_reg6", 64'(regs_out[55:48]), 64'(8'h01));
        checkOutput("wrap_reg0", 64'(regs_out[7:0]), 64'(8'h03));
        checkRegs("wrap_regs");

        // rx_valid held for three cycles counts once
        ackBase = ackCount;
        startFrame();
        sendCmd(8'h04);
        regModel[4] = 8'h9C;
        wrQ.push_back(3'd4);
        txQ.push_back(IDLE_BYTE);
        @(negedge clk);
        rx_data  = 8'h9C;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        endFrame();
        checkOutput("hold_acks", 64'(ackCount - ackBase), 64'(2));
        checkRegs("hold_regs");

        // cs deassert between command and data: next byte is a new command
        startFrame();
        sendCmd(8'h01);
        endFrame();
        startFrame();
        sendCmd(8'h33);
        endFrame();
        checkRegs("cs_break_regs");
        checkOutput("cs_break_wrq", 64'(wrQ.size()), 64'(0));

        // reset in the middle of a write burst
        startFrame();
        sendCmd(8'h00);
        sendWrite(8'h44);
        @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        checkOutput("midrst_regs", 64'(regs_out), 64'(0));
        checkOutput("midrst_tx", 64'(tx_data), 64'(IDLE_BYTE));
        checkOutput("midrst_ack", 64'(rx_ack), 64'(0));
        checkOutput("midrst_stb", 64'(wr_stb), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) regModel[i] = 8'h00;
        ackBase = ackCount;
        repeat (6) @(negedge clk);
        checkOutput("post_rst_no_ack", 64'(ackCount - ackBase), 64'(0));
        rx_valid = 1'b0;
        endFrame();
        startFrame();
        sendCmd(8'h05);
        sendWrite(8'hE7);
        endFrame();
        checkRegs("post_rst_regs");

        checkOutput("txq_empty", 64'(txQ.size()), 64'(0));
        checkOutput("wrq_empty", 64'(wrQ.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
